alu: RTL and testbench



---
 rtl/alu.sv | 131 +++++++++++++
 tb/tb_alu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8-bit execute-stage ALU: 32 operations selected by Opcode, result and
// carry/flag registered one cycle after the operands are sampled.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [4:0]  Opcode,
  output logic [15:0] ALU_Out,
  output logic        CarryOut
);

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_MUL    = 5'h02;
  localparam logic [4:0] OP_DIV    = 5'h03;
  localparam logic [4:0] OP_SHL    = 5'h04;
  localparam logic [4:0] OP_SHR    = 5'h05;
  localparam logic [4:0] OP_ROL    = 5'h06;
  localparam logic [4:0] OP_ROR    = 5'h07;
  localparam logic [4:0] OP_AND    = 5'h08;
  localparam logic [4:0] OP_OR     = 5'h09;
  localparam logic [4:0] OP_XOR    = 5'h0A;
  localparam logic [4:0] OP_NOR    = 5'h0B;
  localparam logic [4:0] OP_NAND   = 5'h0C;
  localparam logic [4:0] OP_XNOR   = 5'h0D;
  localparam logic [4:0] OP_GT     = 5'h0E;
  localparam logic [4:0] OP_EQ     = 5'h0F;
  localparam logic [4:0] OP_INC    = 5'h10;
  localparam logic [4:0] OP_DEC    = 5'h11;
  localparam logic [4:0] OP_NOT    = 5'h12;
  localparam logic [4:0] OP_ASR    = 5'h13;
  localparam logic [4:0] OP_SHLV   = 5'h14;
  localparam logic [4:0] OP_SHRV   = 5'h15;
  localparam logic [4:0] OP_SMUL   = 5'h16;
  localparam logic [4:0] OP_LT     = 5'h17;
  localparam logic [4:0] OP_MAX    = 5'h18;
  localparam logic [4:0] OP_MIN    = 5'h19;
  localparam logic [4:0] OP_PASSA  = 5'h1A;
  localparam logic [4:0] OP_PASSB  = 5'h1B;
  localparam logic [4:0] OP_CAT    = 5'h1C;
  localparam logic [4:0] OP_POPCNT = 5'h1D;
  localparam logic [4:0] OP_BREV   = 5'h1E;

  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [15:0] prod;
  logic [15:0] sprod;
  logic [7:0]  div_b;
  logic [7:0]  quot;
  logic [7:0]  rem;
  logic [3:0]  pcnt;
  logic [7:0]  brev;
  logic [15:0] res;
  logic        cy;

  assign sum9  = {1'b0, A} + {1'b0, B};
  assign diff9 = {1'b0, A} - {1'b0, B};
  assign prod  = {8'h00, A} * {8'h00, B};
  assign sprod = $signed({{8{A[7]}}, A}) * $signed({{8{B[7]}}, B});
  // Divisor forced non-zero so the divider never sees B=0; that case is overridden below.
  assign div_b = (B == 8'h00) ? 8'h01 : B;
  assign quot  = A / div_b;
  assign rem   = A % div_b;

  always_comb begin
    pcnt = 4'd0;
    brev = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pcnt    = pcnt + {3'b000, A[i]};
      brev[i] = A[7-i];
    end
  end

  always_comb begin
    res = 16'h0000;
    cy  = 1'b0;
    case (Opcode)
      OP_ADD:    begin res = {8'h00, sum9[7:0]};  cy = sum9[8];  end
      OP_SUB:    begin res = {8'h00, diff9[7:0]}; cy = diff9[8]; end
      OP_MUL:    begin res = prod;                cy = |prod[15:8]; end
      OP_DIV: begin
        if (B == 8'h00) begin
          res = 16'hFFFF;
          cy  = 1'b1;
        end else begin
          res = {rem, quot};
        end
      end
      OP_SHL:    begin res = {8'h00, A[6:0], 1'b0}; cy = A[7]; end
      OP_SHR:    begin res = {8'h00, 1'b0, A[7:1]}; cy = A[0]; end
      OP_ROL:    res = {8'h00, A[6:0], A[7]};
      OP_ROR:    res = {8'h00, A[0], A[7:1]};
      OP_AND:    res = {8'h00, A & B};
      OP_OR:     res = {8'h00, A | B};
      OP_XOR:    res = {8'h00, A ^ B};
      OP_NOR:    res = {8'h00, ~(A | B)};
      OP_NAND:   res = {8'h00, ~(A & B)};
      OP_XNOR:   res = {8'h00, ~(A ^ B)};
      OP_GT:     res = {15'h0000, A > B};
      OP_EQ:     res = {15'h0000, A == B};
      OP_INC:    begin res = {8'h00, A + 8'h01}; cy = (A == 8'hFF); end
      OP_DEC:    begin res = {8'h00, A - 8'h01}; cy = (A == 8'h00); end
      OP_NOT:    res = {8'h00, ~A};
      OP_ASR:    begin res = {8'h00, A[7], A[7:1]}; cy = A[0]; end
      OP_SHLV:   res = {8'h00, A << B[2:0]};
      OP_SHRV:   res = {8'h00, A >> B[2:0]};
      OP_SMUL:   res = sprod;
      OP_LT:     res = {15'h0000, A < B};
      OP_MAX:    res = {8'h00, (A > B) ? A : B};
      OP_MIN:    res = {8'h00, (A < B) ? A : B};
      OP_PASSA:  res = {8'h00, A};
      OP_PASSB:  res = {8'h00, B};
      OP_CAT:    res = {A, B};
      OP_POPCNT: res = {12'h000, pcnt};
      OP_BREV:   res = {8'h00, brev};
      default:   res = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Out  <= 16'h0000;
      CarryOut <= 1'b0;
    end else begin
      ALU_Out  <= res;
      CarryOut <= cy;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: arithmetic reference model with an expected queue, one
// negedge compare process, and literal vectors that pin the model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [4:0]  Opcode;
  logic [15:0] ALU_Out;
  logic        CarryOut;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Opcode   (Opcode),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {carry, result} from plain integer arithmetic.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [4:0] op);
    int ua, ub, sa, sb, r;
    bit c;
    ua = a;
    ub = b;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    r  = 0;
    c  = 1'b0;
    case (op)
      5'h00: begin r = (ua + ub) & 255; c = (ua + ub) > 255; end
      5'h01: begin r = (ua - ub) & 255; c = ua < ub; end
      5'h02: begin r = ua * ub; c = r > 255; end
      5'h03: begin
        if (ub == 0) begin r = 65535; c = 1'b1; end
        else r = (ua % ub) * 256 + ua / ub;
      end
      5'h04: begin r = (ua * 2) & 255; c = ua >= 128; end
      5'h05: begin r = ua / 2; c = (ua % 2) == 1; end
      5'h06: r = ((ua * 2) & 255) + ua / 128;
      5'h07: r = ua / 2 + (ua % 2) * 128;
      5'h08: r = ua & ub;
      5'h09: r = ua | ub;
      5'h0A: r = ua ^ ub;
      5'h0B: r = 255 - (ua | ub);
      5'h0C: r = 255 - (ua & ub);
      5'h0D: r = 255 - (ua ^ ub);
      5'h0E: r = (ua > ub) ? 1 : 0;
      5'h0F: r = (ua == ub) ? 1 : 0;
      5'h10: begin r = (ua + 1) % 256; c = ua == 255; end
      5'h11: begin r = (ua + 255) % 256; c = ua == 0; end
      5'h12: r = 255 - ua;
      5'h13: begin r = (sa >>> 1) & 255; c = (ua % 2) == 1; end
      5'h14: r = (ua << (ub % 8)) & 255;
      5'h15: r = ua >> (ub % 8);
      5'h16: r = (sa * sb) & 65535;
      5'h17: r = (ua < ub) ? 1 : 0;
      5'h18: r = (ua > ub) ? ua : ub;
      5'h19: r = (ua < ub) ? ua : ub;
      5'h1A: r = ua;
      5'h1B: r = ub;
      5'h1C: r = ua * 256 + ub;
      5'h1D: for (int i = 0; i < 8; i++) r = r + ((ua >> i) & 1);
      5'h1E: for (int i = 0; i < 8; i++) if (((ua >> i) & 1) == 1) r = r + (1 << (7 - i));
      default: r = 0;
    endcase
    return {c, r[15:0]};
  endfunction

  // Each accepted edge enqueues what the registered outputs must show after it.
  always @(posedge clk) begin
    if (rst_n === 1'b1) exp_q.push_back(model(A, B, Opcode));
  end

  // scoreboard compare
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      n_cmp++;
      if (ALU_Out !== 16'h0000 || CarryOut !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_cycle: got %h/%b, required 0000/0", ALU_Out, CarryOut);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({CarryOut, ALU_Out} !== e) begin
        n_fail++;
        $display("FAIL model_cmp: got %h/%b, required %h/%b", ALU_Out, CarryOut, e[15:0], e[16]);
      end
    end
  end

  // driver tasks
  task automatic check_now(input string name, input logic [15:0] eo, input logic ec);
    n_cmp++;
    if (ALU_Out !== eo || CarryOut !== ec) begin
      n_fail++;
      $display("FAIL %s: got %h/%b, required %h/%b", name, ALU_Out, CarryOut, eo, ec);
    end
  endtask

  task automatic check_vec(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op,
                           input logic [15:0] eo, input logic ec, input string name);
    logic [16:0] m;
    @(negedge clk);
    A = a;
    B = b;
    Opcode = op;
    @(posedge clk);
    #1;
    check_now(name, eo, ec);
    m = model(a, b, op);
    n_cmp++;
    if (m !== {ec, eo}) begin
      n_fail++;
      $display("FAIL model_pin_%s: model %h/%b, required %h/%b", name, m[15:0], m[16], eo, ec);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    A      = 8'h00;
    B      = 8'h00;
    Opcode = 5'h00;
    #3;
    check_now("reset_state", 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    check_vec(8'hE7, 8'h98, 5'h00, 16'h007F, 1'b1, "add");
    check_vec(8'hE7, 8'h98, 5'h01, 16'h004F, 1'b0, "sub");
    check_vec(8'hE7, 8'h98, 5'h05, 16'h0073, 1'b1, "shr");
    check_vec(8'hE7, 8'h98, 5'h03, 16'h4F01, 1'b0, "div");
    // -25 * -104 = 2600 = 0x0A28
    check_vec(8'hE7, 8'h98, 5'h16, 16'h0A28, 1'b0, "smul");
    check_vec(8'h10, 8'h20, 5'h01, 16'h00F0, 1'b1, "sub_borrow");
    check_vec(8'hFF, 8'h00, 5'h10, 16'h0000, 1'b1, "inc_wrap");
    check_vec(8'h00, 8'h00, 5'h11, 16'h00FF, 1'b1, "dec_wrap");
    check_vec(8'h37, 8'h00, 5'h03, 16'hFFFF, 1'b1, "div_zero");
    check_vec(8'hA5, 8'h3C, 5'h1C, 16'hA53C, 1'b0, "cat");
    check_vec(8'hA5, 8'h3C, 5'h1D, 16'h0004, 1'b0, "popcnt");
    check_vec(8'hA5, 8'h3C, 5'h1E, 16'h00A5, 1'b0, "brev_sym");
    check_vec(8'h01, 8'h3C, 5'h1E, 16'h0080, 1'b0, "brev");
    check_vec(8'h81, 8'h00, 5'h13, 16'h00C0, 1'b1, "asr");
    check_vec(8'h81, 8'h00, 5'h06, 16'h0003, 1'b0, "rol");
    check_vec(8'h81, 8'h05, 5'h14, 16'h0020, 1'b0, "shlv");
    check_vec(8'h5A, 8'h5A, 5'h0F, 16'h0001, 1'b0, "eq");
    check_vec(8'hFF, 8'hFF, 5'h1F, 16'h0000, 1'b0, "nop");

    // opcode sweep, back-to-back, random operands
    for (int round = 0; round < 6; round++) begin
      for (int op = 0; op < 32; op++) begin
        @(negedge clk);
        A      = 8'($urandom_range(0, 255));
        B      = (round == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        Opcode = 5'(op);
      end
    end

    // asynchronous reset in the middle of a cycle while 8928 is showing
    check_vec(8'hE7, 8'h98, 5'h02, 16'h8928, 1'b1, "mul_pre_reset");
    #1 rst_n = 1'b0;
    #1 check_now("reset_async", 16'h0000, 1'b0);
    @(posedge clk);
    #1 check_now("reset_hold", 16'h0000, 1'b0);
    @(negedge clk);
    A      = 8'hA5;
    B      = 8'h3C;
    Opcode = 5'h1C;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check_now("after_release", 16'hA53C, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, required at most 1", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
